// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Producer side of the Fetch -> Decode boundary. Holds the fetch PC, issues
// pipelined requests to instruction memory over a req/gnt/rvalid handshake,
// buffers returned instructions in an in-order queue and presents the queue
// head to the F->D pipeline register. Obeys the hazard stall and flushes on
// an execute-stage redirect.
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   stall_f_i        hazard stall (holds the F->D register)
//   pc_src_e_i       redirect request from execute
//   pc_target_e_i    redirect target (word-aligned internally)
//   imem_req_o       memory request valid
//   imem_addr_o      request word address
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    response valid
//   imem_rdata_i     response instruction
//   rd_f_o           instruction to the F->D register
//   pc_f_o           PC of rd_f_o
//   pc_plus4_f_o     pc_f_o + 4
//   instr_valid_f_o  queue head valid
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_f_i,
    input  logic        pc_src_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] rd_f_o,
    output logic [31:0] pc_f_o,
    output logic [31:0] pc_plus4_f_o,
    output logic        instr_valid_f_o
);

    // Counters hold values 0..DEPTH (DEPTH <= 4); storage is sized to the
    // full pointer range so every pointer value indexes a real entry.
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned SLOTS   = 4;
    localparam logic [CNT_W:0]   DEPTH_C  = 4'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = 2'(DEPTH - 1);

    // Circular pointer advance, wrapping at the configured depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = 2'd0;
        end else begin
            nxt = ptr + 2'd1;
        end
        return nxt;
    endfunction

    logic [31:0]      fetch_pc_r;
    logic [31:0]      q_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      q_instr_r [SLOTS];
    logic [31:0]      q_addr_r  [SLOTS];

    logic [CNT_W:0]   slots_used_s;
    logic             req_s;
    logic             gnt_fire_s;
    logic             rsp_ok_s;
    logic             rsp_drop_s;
    logic             push_s;
    logic             valid_s;
    logic             pop_s;
    logic [31:0]      target_s;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [31:0]      rd_f_s;
    logic [31:0]      pc_f_s;

    // In-flight requests and buffered entries share the DEPTH budget, so a
    // response can always be pushed without checking for space.
    assign slots_used_s = {1'b0, outstanding_r} + {1'b0, count_r};
    assign req_s        = rst_ni & ~pc_src_e_i & (slots_used_s < DEPTH_C);
    assign gnt_fire_s   = req_s & imem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok_s     = imem_rvalid_i & (outstanding_r != 3'd0);
    assign rsp_drop_s   = rsp_ok_s & (discard_r != 3'd0);
    assign push_s       = rsp_ok_s & ~rsp_drop_s & ~pc_src_e_i;

    assign valid_s      = rst_ni & (count_r != 3'd0);
    assign pop_s        = valid_s & ~stall_f_i & ~pc_src_e_i;

    // Masking (rather than slicing) keeps every target bit in use.
    assign target_s     = pc_target_e_i & 32'hFFFF_FFFC;

    // In-flight count after this cycle's grant and response accounting.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({gnt_fire_s, rsp_ok_s})
            2'b10:   outstanding_nxt_s = outstanding_r + 3'd1;
            2'b01:   outstanding_nxt_s = outstanding_r - 3'd1;
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // Control state: fetch PC, queue-side PC, counters and pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_r    <= RESET_PC;
            q_pc_r        <= RESET_PC;
            outstanding_r <= 3'd0;
            discard_r     <= 3'd0;
            count_r       <= 3'd0;
            rd_ptr_r      <= 2'd0;
            wr_ptr_r      <= 2'd0;
        end else if (pc_src_e_i) begin
            // Redirect wins over stall, push and pop; every response still
            // in flight after this edge belongs to the old path.
            fetch_pc_r    <= target_s;
            q_pc_r        <= target_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= outstanding_nxt_s;
            count_r       <= 3'd0;
            rd_ptr_r      <= 2'd0;
            wr_ptr_r      <= 2'd0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (gnt_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (rsp_drop_s) begin
                discard_r <= discard_r - 3'd1;
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
                q_pc_r   <= q_pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage: instruction word and its PC, written on push.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < SLOTS; i++) begin
                q_instr_r[i] <= NOP_INSTR;
                q_addr_r[i]  <= 32'd0;
            end
        end else if (push_s) begin
            q_instr_r[wr_ptr_r] <= imem_rdata_i;
            q_addr_r[wr_ptr_r]  <= q_pc_r;
        end
    end

    // Head presentation; responses never bypass the queue into the outputs.
    always_comb begin
        rd_f_s = NOP_INSTR;
        pc_f_s = 32'd0;
        if (valid_s) begin
            rd_f_s = q_instr_r[rd_ptr_r];
            pc_f_s = q_addr_r[rd_ptr_r];
        end else begin
            rd_f_s = NOP_INSTR;
            pc_f_s = 32'd0;
        end
    end

    assign imem_req_o      = req_s;
    assign imem_addr_o     = fetch_pc_r;
    assign rd_f_o          = rd_f_s;
    assign pc_f_o          = pc_f_s;
    assign pc_plus4_f_o    = pc_f_s + 32'd4;
    assign instr_valid_f_o = valid_s;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage (DEPTH = 2). A small in-order memory model
// answers each granted request one or more cycles later with rdata =
// addr | 0x100. Per-cycle inputs and hand-computed expected outputs live in a
// vector table; reset-in-flight and PC wrap are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk_i;
    logic        rst_ni;
    logic        stall_f_i;
    logic        pc_src_e_i;
    logic [31:0] pc_target_e_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] rd_f_o;
    logic [31:0] pc_f_o;
    logic [31:0] pc_plus4_f_o;
    logic        instr_valid_f_o;

    int n_cmp;
    int n_fail;

    logic [31:0] mem_q [$];

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] tg;
        logic        g;
        logic        rs;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq [$];

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR),
        .DEPTH    (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .stall_f_i      (stall_f_i),
        .pc_src_e_i     (pc_src_e_i),
        .pc_target_e_i  (pc_target_e_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .rd_f_o         (rd_f_o),
        .pc_f_o         (pc_f_o),
        .pc_plus4_f_o   (pc_plus4_f_o),
        .instr_valid_f_o(instr_valid_f_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    // Memory protocol guard: a response is only ever driven for a granted request.
    always @(negedge clk_i) begin
        if (rst_ni && imem_rvalid_i) begin
            assert (mem_q.size() > 0) else $error("rvalid driven with no request outstanding");
        end
    end

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tg,
                         input logic g, input logic rs);
        stall_f_i     = st;
        pc_src_e_i    = rd;
        pc_target_e_i = tg;
        imem_gnt_i    = g;
        if (rs && mem_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_q[0] | 32'h0000_0100;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0000_0000;
        end
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_rd);
        logic [31:0] x_rd;
        logic [31:0] x_pc;
        x_rd = e_v ? e_rd : NOP_INSTR;
        x_pc = e_v ? e_pc : 32'd0;
        cmp(tag, "req",   {31'd0, imem_req_o},      {31'd0, e_req});
        cmp(tag, "addr",  imem_addr_o,              e_addr);
        cmp(tag, "valid", {31'd0, instr_valid_f_o}, {31'd0, e_v});
        cmp(tag, "rd",    rd_f_o,                   x_rd);
        cmp(tag, "pc",    pc_f_o,                   x_pc);
        cmp(tag, "pc4",   pc_plus4_f_o,             x_pc + 32'd4);
    endtask

    // Clock edge plus memory-model bookkeeping (in-order response queue).
    task automatic advance();
        logic        fire;
        logic        rv;
        logic [31:0] a;
        fire = imem_req_o & imem_gnt_i;
        rv   = imem_rvalid_i;
        a    = imem_addr_o;
        @(posedge clk_i);
        if (!rst_ni) begin
            mem_q.delete();
        end else begin
            if (rv && mem_q.size() > 0) mem_q.delete(0);
            if (fire) mem_q.push_back(a);
        end
        #1;
    endtask

    task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] tg,
                        input logic g, input logic rs, input logic e_req, input logic [31:0] e_addr,
                        input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_rd);
        drive(st, rd, tg, g, rs);
        check_out(tag, e_req, e_addr, e_v, e_pc, e_rd);
        advance();
    endtask

    task automatic add_vec(input logic st, input logic rd, input logic [31:0] tg,
                           input logic g, input logic rs, input logic e_req,
                           input logic [31:0] e_addr, input logic e_v,
                           input logic [31:0] e_pc, input logic [31:0] e_rd);
        vec_t v;
        v.st = st; v.rd = rd; v.tg = tg; v.g = g; v.rs = rs;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //       st    rd    target        gnt   rsp   req   addr          v     pc            rd
        // streaming from reset: 2-cycle grant-to-output latency
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_0100);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0104);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,        32'h0);
        // three stall cycles: head holds pc 0x8, request stops once both slots are used
        add_vec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_0108);
        add_vec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_0108);
        add_vec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_0108);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'h0000_0108);
        // grant held low 4 cycles: address stable, queue drains to NOP
        add_vec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_010C);
        add_vec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,        32'h0);
        // two requests (0x10, 0x14) go out with responses held back
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 32'h0,        32'h0);
        // redirect to 0x200: both old responses dropped
        add_vec(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 32'h0000_0018, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0,        32'h0);
        // redirect with stall in the same cycle, unaligned target 0x403
        add_vec(1'b1, 1'b1, 32'h0000_0403, 1'b1, 1'b1, 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200, 32'h0000_0300);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0404, 1'b0, 32'h0,        32'h0);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0408, 1'b1, 32'h0000_0400, 32'h0000_0500);
        add_vec(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0408, 1'b1, 32'h0000_0404, 32'h0000_0504);
        // stall until the queue is full, ahead of the mid-stream reset
        add_vec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_040C, 1'b0, 32'h0,        32'h0);
        add_vec(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0410, 1'b1, 32'h0000_0408, 32'h0000_0508);

        // Reset state
        rst_ni        = 1'b0;
        stall_f_i     = 1'b0;
        pc_src_e_i    = 1'b0;
        pc_target_e_i = 32'd0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        advance();
        advance();
        step("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
        rst_ni = 1'b1;

        foreach (vq[i]) begin
            step($sformatf("vec%0d", i), vq[i].st, vq[i].rd, vq[i].tg, vq[i].g, vq[i].rs,
                 vq[i].e_req, vq[i].e_addr, vq[i].e_v, vq[i].e_pc, vq[i].e_rd);
        end

        // Reset with a full queue: outputs forced quiet, restart from RESET_PC
        rst_ni = 1'b0;
        step("rst_mid",  1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0410, 1'b0, 32'h0, 32'h0);
        step("rst_hold", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, RESET_PC,      1'b0, 32'h0, 32'h0);
        rst_ni = 1'b1;
        step("rst_rel0", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, RESET_PC,      1'b0, 32'h0, 32'h0);
        step("rst_rel1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0);
        step("rst_rel2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'h0000_0100);

        // Fetch PC and queue PC wrap from 0xFFFF_FFFC to 0
        step("wrap0", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0104);
        step("wrap1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        step("wrap2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        step("wrap3", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        step("wrap4", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
